// File: rtl/packed_frame_loader.sv
// packed_frame_loader
// Collects a serial stream of W-bit elements into a packed ROWS x COLS frame
// and hands the finished frame downstream over a valid/ready handshake.
// A registered random-access port returns frame[rd_row][rd_col] one cycle later.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting elements, row-major, into frame; in_ready high
// HOLD  | frame complete and stable; frame_valid high, waits frame_ready
module packed_frame_loader #(
  parameter  int ROWS = 2,
  parameter  int COLS = 3,
  parameter  int W    = 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int NW   = $clog2(ROWS*COLS+1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [W-1:0]                       in_data,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [ROWS-1:0][COLS-1:0][W-1:0]   frame,
  output logic [NW-1:0]                      elem_count,
  input  logic [RW-1:0]                      rd_row,
  input  logic [CW-1:0]                      rd_col,
  output logic [W-1:0]                       rd_data
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          rd_in_range;

  // Handshake flags come straight off the state register, never from inputs.
  assign in_ready    = (state == FILL);
  assign frame_valid = (state == HOLD);
  assign accept      = in_valid && (state == FILL);

  // Index widths may reach past the array bounds (e.g. column 3 of 3).
  assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

  // Fill/hold sequencing, pointer advance and frame storage; flush wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      row        <= '0;
      col        <= '0;
      elem_count <= '0;
      frame      <= '0;
    end else if (flush) begin
      state      <= FILL;
      row        <= '0;
      col        <= '0;
      elem_count <= '0;
      frame      <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            frame[row][col] <= in_data;
            elem_count      <= elem_count + NW'(1);
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= HOLD;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        HOLD: begin
          // Contents stay in place after handoff; the next fill overwrites them.
          if (frame_ready) begin
            state      <= FILL;
            elem_count <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Registered element read, zero for out-of-range indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= frame[rd_row][rd_col];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_packed_frame_loader.sv
// Bench for packed_frame_loader: directed scenarios then random traffic,
// all checked against a flat-array model of the frame.
module tb_packed_frame_loader;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int W    = 4;
  localparam int N    = ROWS*COLS;

  logic                             clk;
  logic                             rst_n;
  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [W-1:0]                     in_data;
  logic                             frame_valid;
  logic                             frame_ready;
  logic [ROWS-1:0][COLS-1:0][W-1:0] frame;
  logic [2:0]                       elem_count;
  logic [0:0]                       rd_row;
  logic [1:0]                       rd_col;
  logic [W-1:0]                     rd_data;

  packed_frame_loader #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame(frame),
    .elem_count(elem_count), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: elements by linear fill index, how many taken, and whether holding.
  logic [W-1:0] m_elem [N];
  int           m_cnt;
  bit           m_hold;
  logic [W-1:0] m_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] m_frame();
    logic [N*W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_elem[i];
    return f;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_elem[i] = '0;
    m_cnt  = 0;
    m_hold = 0;
    m_rd   = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".frame"}, 64'(frame), 64'(m_frame()));
    chk({tag, ".cnt"}, 64'(elem_count), 64'(m_cnt));
    chk({tag, ".fv"}, 64'(frame_valid), 64'(m_hold));
    chk({tag, ".ir"}, 64'(in_ready), 64'(!m_hold));
    chk({tag, ".rd"}, 64'(rd_data), 64'(m_rd));
  endtask

  // One clock: model the edge using the inputs driven before it, then check.
  task automatic step(input string tag);
    logic [W-1:0] nxt_rd;
    if (int'(rd_row) < ROWS && int'(rd_col) < COLS)
      nxt_rd = m_elem[int'(rd_row)*COLS + int'(rd_col)];
    else
      nxt_rd = '0;
    @(posedge clk);
    m_rd = nxt_rd;
    if (flush) begin
      for (int i = 0; i < N; i++) m_elem[i] = '0;
      m_cnt  = 0;
      m_hold = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_elem[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == N) m_hold = 1;
      end
    end else if (frame_ready) begin
      m_hold = 0;
      m_cnt  = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic feed(input logic [W-1:0] d, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    step(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ld1 [N];
    logic [W-1:0] ld2 [N];
    ld1 = '{4'd5, 4'd14, 4'd6, 4'd5, 4'd14, 4'd6};
    ld2 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    frame_ready = 1'b0; rd_row = '0; rd_col = '0;
    m_clear();
    #12 rst_n = 1'b1;
    #1 check_all("reset");

    // First load with downstream stalled.
    for (int i = 0; i < N; i++) feed(ld1[i], "load1");
    chk("load1.frame_const", 64'(frame), 64'h6E56E5);
    chk("load1.f00", 64'(frame[0][0]), 64'd5);
    chk("load1.f01", 64'(frame[0][1]), 64'd14);
    chk("load1.f10", 64'(frame[1][0]), 64'd5);
    chk("load1.f12", 64'(frame[1][2]), 64'd6);
    chk("load1.cnt_const", 64'(elem_count), 64'd6);
    chk("load1.fv_const", 64'(frame_valid), 64'd1);

    // Elements offered during HOLD must be ignored.
    for (int i = 0; i < 3; i++) feed(4'hF, "hold_ign");
    chk("hold.frame_const", 64'(frame), 64'h6E56E5);

    // Handoff: contents retained, count cleared.
    frame_ready = 1'b1;
    step("handoff");
    frame_ready = 1'b0;
    chk("handoff.frame_const", 64'(frame), 64'h6E56E5);
    chk("handoff.cnt_const", 64'(elem_count), 64'd0);
    chk("handoff.ir_const", 64'(in_ready), 64'd1);

    for (int i = 0; i < N; i++) feed(ld2[i], "load2");
    chk("load2.frame_const", 64'(frame), 64'h654321);

    rd_row = 1'd1; rd_col = 2'd1;
    step("rd11");
    chk("rd11.const", 64'(rd_data), 64'd5);
    rd_col = 2'd3;
    step("rd_oob");
    chk("rd_oob.const", 64'(rd_data), 64'd0);
    rd_row = '0; rd_col = '0;

    frame_ready = 1'b1;
    step("handoff2");
    frame_ready = 1'b0;

    // Sparse valid: idle cycles between accepts.
    for (int i = 0; i < 3; i++) begin
      feed(4'(4'hA + i), "sparse");
      step("sparse_idle");
    end
    chk("sparse.cnt_const", 64'(elem_count), 64'd3);
    chk("sparse.f02", 64'(frame[0][2]), 64'hC);

    // Flush collides with an accept; the element is dropped.
    flush = 1'b1;
    feed(4'h9, "flush");
    flush = 1'b0;
    chk("flush.frame_const", 64'(frame), 64'd0);
    chk("flush.cnt_const", 64'(elem_count), 64'd0);

    // Fill to HOLD, then async reset between edges.
    for (int i = 0; i < N; i++) feed(4'(i + 7), "load3");
    rd_row = 1'd0; rd_col = 2'd1;
    step("load3_rd");
    #3 rst_n = 1'b0;
    #1;
    m_clear();
    chk("async.frame", 64'(frame), 64'd0);
    chk("async.fv", 64'(frame_valid), 64'd0);
    chk("async.rd", 64'(rd_data), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("async.ir", 64'(in_ready), 64'd1);
    rd_row = '0; rd_col = '0;

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = W'($urandom);
      frame_ready = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      rd_row      = 1'($urandom_range(0, 1));
      rd_col      = 2'($urandom_range(0, 3));
      step("rand");
    end
    in_valid = 1'b0; frame_ready = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
